product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 116 +++++++++++
 tb/tb_product_accumulator.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Signed product accumulator: sums 64-bit products into ACC_W-bit groups and hands each group result downstream.
// Build option: define PRODUCT_ACCUMULATOR_SAT_EN to clamp overflowing adds instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      p,
  input  logic             p_valid,
  input  logic             p_last,
  output logic             p_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic [15:0]      cnt_out,
  output logic             ovf_out,
  output logic             o_valid,
  input  logic             o_ready
);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ACC_W-1:0] r_acc;
  logic [15:0]      r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic [ACC_W-1:0] w_base;
  logic [15:0]      w_base_cnt;
  logic             w_base_ovf;
  logic [ACC_W-1:0] w_sext;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;
  logic [ACC_W-1:0] w_result;
  logic [15:0]      w_cnt_inc;
  logic             w_ovf_new;

  assign w_accept = p_valid && (r_state == S_ACC);

  // clr coincident with an accept makes p the first product of a fresh group
  assign w_base     = clr ? '0    : r_acc;
  assign w_base_cnt = clr ? 16'd0 : r_cnt;
  assign w_base_ovf = clr ? 1'b0  : r_ovf;

  assign w_sext    = {{(ACC_W-64){p[63]}}, p};
  assign w_sum     = w_base + w_sext;
  assign w_add_ovf = (w_base[ACC_W-1] == w_sext[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != w_base[ACC_W-1]);

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Overflow only happens when both operands share a sign, so the base sign gives the direction
  assign w_result = w_add_ovf ? (w_base[ACC_W-1] ? SAT_MIN : SAT_MAX) : w_sum;
`else
  assign w_result = w_sum;
`endif

  assign w_cnt_inc = (w_base_cnt == 16'hFFFF) ? 16'hFFFF : w_base_cnt + 16'd1;
  assign w_ovf_new = w_base_ovf | w_add_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACC:   if (w_accept && p_last) w_state_next = S_HOLD;
      S_HOLD:  if (o_ready) w_state_next = S_ACC;
      default: w_state_next = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_cnt   <= 16'd0;
      r_ovf   <= 1'b0;
      acc_out <= '0;
      cnt_out <= 16'd0;
      ovf_out <= 1'b0;
    end else if (w_accept) begin
      if (p_last) begin
        acc_out <= w_result;
        cnt_out <= w_cnt_inc;
        ovf_out <= w_ovf_new;
        r_acc   <= '0;
        r_cnt   <= 16'd0;
        r_ovf   <= 1'b0;
      end else begin
        r_acc <= w_result;
        r_cnt <= w_cnt_inc;
        r_ovf <= w_ovf_new;
      end
    end else if (clr && (r_state == S_ACC)) begin
      r_acc <= '0;
      r_cnt <= 16'd0;
      r_ovf <= 1'b0;
    end
  end

  assign p_ready = (r_state == S_ACC);
  assign o_valid = (r_state == S_HOLD);

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: an 80-bit and a 65-bit instance share one stimulus stream,
// each checked against an exact-arithmetic model (wrap or clamp chosen by PRODUCT_ACCUMULATOR_SAT_EN).
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] p = '0;
  logic        p_valid = 1'b0;
  logic        p_last = 1'b0;
  logic        clr = 1'b0;
  logic        o_ready = 1'b1;

  logic        p_ready_a, o_valid_a, ovf_a;
  logic [79:0] acc_a;
  logic [15:0] cnt_a;
  logic        p_ready_b, o_valid_b, ovf_b;
  logic [64:0] acc_b;
  logic [15:0] cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  int ready_mode = 1;  // 0: hold o_ready low, 1: high, 2: random

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(80)) u_dut80 (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .p_last(p_last), .p_ready(p_ready_a),
    .clr(clr), .acc_out(acc_a), .cnt_out(cnt_a), .ovf_out(ovf_a), .o_valid(o_valid_a), .o_ready(o_ready)
  );

  product_accumulator #(.ACC_W(65)) u_dut65 (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .p_last(p_last), .p_ready(p_ready_b),
    .clr(clr), .acc_out(acc_b), .cnt_out(cnt_b), .ovf_out(ovf_b), .o_valid(o_valid_b), .o_ready(o_ready)
  );

  typedef struct {
    logic signed [129:0] acc;
    int                  cnt;
    bit                  ovf;
  } res_t;

  res_t q80[$];
  res_t q65[$];

  localparam logic signed [129:0] ONE = 130'sd1;
  int                  w_of [2] = '{80, 65};
  logic signed [129:0] m_acc [2];
  bit                  m_ovf [2];
  int                  m_cnt;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = '0;
      m_ovf[k] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Exact arithmetic, then range test: out of [-2^(W-1), 2^(W-1)-1] means overflow
  task automatic model_accept(input logic [63:0] pv, input bit last, input bit c);
    logic signed [129:0] base, exact, hi, lo, span;
    bit ov, nov;
    int ncnt;
    res_t r;
    ncnt = c ? 0 : m_cnt;
    ncnt = (ncnt >= 65535) ? 65535 : ncnt + 1;
    for (int k = 0; k < 2; k++) begin
      base  = c ? '0 : m_acc[k];
      exact = base + $signed({{66{pv[63]}}, pv});
      hi    = (ONE <<< (w_of[k] - 1)) - ONE;
      lo    = -(ONE <<< (w_of[k] - 1));
      span  = ONE <<< w_of[k];
      ov    = (exact > hi) || (exact < lo);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
      if (exact > hi) exact = hi;
      else if (exact < lo) exact = lo;
`else
      if (exact > hi) exact = exact - span;
      else if (exact < lo) exact = exact + span;
`endif
      nov = (c ? 1'b0 : m_ovf[k]) | ov;
      if (last) begin
        r.acc = exact;
        r.cnt = ncnt;
        r.ovf = nov;
        if (k == 0) q80.push_back(r);
        else q65.push_back(r);
        m_acc[k] = '0;
        m_ovf[k] = 1'b0;
      end else begin
        m_acc[k] = exact;
        m_ovf[k] = nov;
      end
    end
    m_cnt = last ? 0 : ncnt;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [63:0] pv, input bit last, input bit c);
    int guard;
    guard = 0;
    p = pv;
    p_valid = 1'b1;
    p_last = last;
    clr = c;
    while (!p_ready_a && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!p_ready_a) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout p_ready=%0b required=1", p_ready_a);
    end else begin
      model_accept(pv, last, c);
      @(posedge clk);
      #1;
      if (last) begin
        chk("latency_o_valid80", 128'(o_valid_a), 128'd1);
        chk("latency_o_valid65", 128'(o_valid_b), 128'd1);
        chk("hold_p_ready", 128'(p_ready_a), 128'd0);
      end
    end
    p_valid = 1'b0;
    p_last = 1'b0;
    clr = 1'b0;
  endtask

  task automatic clr_idle();
    clr = 1'b1;
    if (p_ready_a) model_clear();
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    ready_mode = 1;
    while (o_valid_a && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_o_valid", 128'(o_valid_a), 128'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_o_valid", {126'd0, o_valid_a, o_valid_b}, 128'd0);
    chk("rst_p_ready", {126'd0, p_ready_a, p_ready_b}, 128'd3);
    chk("rst_acc80", 128'(acc_a), 128'd0);
    chk("rst_acc65", 128'(acc_b), 128'd0);
    chk("rst_cnt_ovf", {94'd0, cnt_a, cnt_b, ovf_a, ovf_b}, 128'd0);
    q80.delete();
    q65.delete();
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       o_ready = 1'b0;
        1:       o_ready = 1'b1;
        default: o_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: while a result is presented it must match the queue head; the handshake retires it
  always @(negedge clk) begin
    if (rst && o_valid_a) begin
      n_chk++;
      if (q80.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result80 acc=%h required no output", acc_a);
      end else begin
        if (acc_a !== q80[0].acc[79:0] || cnt_a !== q80[0].cnt[15:0] || ovf_a !== q80[0].ovf) begin
          n_fail++;
          $display("FAIL result80 got acc=%h cnt=%0d ovf=%0b exp acc=%h cnt=%0d ovf=%0b",
                   acc_a, cnt_a, ovf_a, q80[0].acc[79:0], q80[0].cnt, q80[0].ovf);
        end
        if (o_ready) begin
          $display("result80 acc=%h cnt=%0d ovf=%0b", acc_a, cnt_a, ovf_a);
          void'(q80.pop_front());
        end
      end
    end
    if (rst && o_valid_b) begin
      n_chk++;
      if (q65.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result65 acc=%h required no output", acc_b);
      end else begin
        if (acc_b !== q65[0].acc[64:0] || cnt_b !== q65[0].cnt[15:0] || ovf_b !== q65[0].ovf) begin
          n_fail++;
          $display("FAIL result65 got acc=%h cnt=%0d ovf=%0b exp acc=%h cnt=%0d ovf=%0b",
                   acc_b, cnt_b, ovf_b, q65[0].acc[64:0], q65[0].cnt, q65[0].ovf);
        end
        if (o_ready) begin
          $display("result65 acc=%h cnt=%0d ovf=%0b", acc_b, cnt_b, ovf_b);
          void'(q65.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int len;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Small mixed-sign group, immediate release
    send(64'd3, 0, 0);
    send(-64'sd5, 0, 0);
    send(64'd7, 1, 0);
    drain();
    chk("kept_acc_after_release", 128'(acc_a), 128'd5);
    chk("kept_cnt_after_release", 128'(cnt_a), 128'd3);

    // Held result with o_ready low: p_ready stays low, outputs checked by monitor each cycle
    ready_mode = 0;
    for (int i = 0; i < 4; i++) send(64'h3FFF_FFFF_0000_0001, (i == 3), 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_stall_p_ready", 128'(p_ready_a), 128'd0);
      chk("hold_acc80", 128'(acc_a), 128'h0000_FFFF_FFFC_0000_0004);
      @(posedge clk);
      #1;
    end
    drain();

    // Near-limit sums for the 65-bit instance
    send(64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    send(64'd0, 1, 0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    send(64'd5, 1, 0);
    send(64'h8000_0000_0000_0000, 0, 0);
    send(64'h8000_0000_0000_0000, 0, 0);
    send(64'h8000_0000_0000_0000, 1, 0);
    drain();

    // clr coincident with the last accept starts a one-product group
    send(64'd10, 0, 0);
    send(64'd20, 0, 0);
    send(64'd4, 1, 1);
    drain();
    chk("clr_accept_acc", 128'(acc_a), 128'd4);
    chk("clr_accept_cnt", 128'(cnt_a), 128'd1);

    // Reset mid-group, then reset while holding
    send(64'd1, 0, 0);
    send(64'd2, 0, 0);
    do_reset();
    ready_mode = 0;
    send(64'd9, 1, 0);
    @(posedge clk);
    #1;
    do_reset();
    ready_mode = 1;
    send(64'd1, 0, 0);
    send(64'd1, 1, 0);
    drain();
    chk("post_reset_acc", 128'(acc_a), 128'd2);

    // Counter saturation
    for (int i = 0; i < 65537; i++) send(64'd1, 0, 0);
    send(64'd1, 1, 0);
    drain();
    chk("sat_cnt", 128'(cnt_a), 128'd65535);
    chk("sat_acc", 128'(acc_a), 128'd65538);

    // Randomized groups with random backpressure, clr and product magnitudes
    ready_mode = 2;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0:       v = 64'($signed($urandom_range(0, 2000)) - 1000);
          1:       v = {$urandom, $urandom};
          2:       v = ($urandom_range(0, 1) != 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
          default: v = {{32{1'b0}}, $urandom};
        endcase
        if ($urandom_range(0, 15) == 0) clr_idle();
        send(v, (i == len - 1), ($urandom_range(0, 9) == 0));
      end
    end
    drain();
    chk("queues_empty", 128'(q80.size() + q65.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
